fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-cycle controller for the microcontroller core. It sequences the program counter (count pulse, bus drive), memory address load, memory read handshake and instruction-register load, and hands the shared bus to the execute unit for the execute phase. It sits between the PC, the instruction memory interface and the execute unit. It also provides halt/single-step debug control and a memory-timeout fault.

## Interface
- MEM_TIMEOUT, 15: maximum cycles `mem_rd` may be held without `mem_ready` before fault.
- CNT_W, 16: width of the retired-instruction counter.

- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_ready  in  1  memory read data valid; sampled while `mem_rd`=1.
- exec_done  in  1  execute unit finished the current instruction.
- halt_req  in  1  level; request halt at the next instruction boundary.
- resume  in  1  pulse; leave HALT and run freely.
- step  in  1  pulse; leave HALT, run exactly one instruction, return to HALT.
- pc_out_en  out  1  PC drives the bus.
- mar_load  out  1  memory address register captures the bus.
- mem_rd  out  1  instruction memory read request.
- ir_load  out  1  instruction register captures memory data.
- pc_count  out  1  one-cycle high pulse; PC advances on its rising edge.
- exec_start  out  1  one-cycle pulse, start of execute phase.
- bus_grant_exec  out  1  execute unit owns the bus.
- halted  out  1  sequencer in HALT.
- fault  out  1  sticky memory-timeout flag.
- instr_count  out  CNT_W  retired instructions.

## Operation
- States: RST, FETCH_ADDR, FETCH_READ, FETCH_LATCH, EXEC, HALT, FAULT.
- Outputs decoded from the registered state. None are combinational from inputs.
- RST is entered asynchronously on reset. It goes to FETCH_ADDR on the first clock after reset deasserts.
- FETCH_ADDR, one cycle: `pc_out_en`=1, `mar_load`=1. Next state is FETCH_READ.
- FETCH_READ: `mem_rd`=1 and the wait timer counts.
  - `mem_ready`=1 goes to FETCH_LATCH.
  - If the timer reaches MEM_TIMEOUT with no `mem_ready`, go to FAULT.
  - `mem_ready` wins if it arrives on the timeout cycle.
- FETCH_LATCH, one cycle: `ir_load`=1, `pc_count`=1. Next state is EXEC.
- EXEC: `bus_grant_exec`=1 throughout. `exec_start`=1 on the entry cycle only. `exec_done` is sampled every EXEC cycle, including the entry cycle.
- On `exec_done`, the instruction retires: `instr_count` increments, wrapping at 2^CNT_W-1 to 0. The next state is then:
  - HALT if `halt_req`=1 or a single-step is in progress;
  - otherwise FETCH_ADDR.
- `halt_req` is acted on only at the instruction boundary. It never aborts a fetch or execute.
- HALT: `halted`=1.
  - `resume` goes to FETCH_ADDR.
  - `step` sets the step flag and goes to FETCH_ADDR.
  - `resume`+`step` together is treated as `resume`.
  - The step flag clears when the stepped instruction retires.
- FAULT: all strobes 0, `fault`=1. Only reset exits.
- Invariant: `pc_out_en` and `bus_grant_exec` are never both 1.

## Timing
- Reset value of every output is 0, including `instr_count`. The step flag and wait timer also reset to 0.
- Minimum instruction: 4 cycles (FETCH_ADDR, FETCH_READ with immediate `mem_ready`, FETCH_LATCH, EXEC with immediate `exec_done`).
- Each extra memory wait cycle or execute cycle adds one cycle.
- The wait timer clears on FETCH_READ entry.
- With `mem_ready` never asserted, FAULT is entered after MEM_TIMEOUT+1 cycles in FETCH_READ. `fault` is visible the cycle after.
- Asserting reset mid-instruction drops all outputs to 0 immediately. No partial `pc_count` pulse may extend past reset.
- `resume`/`step` pulses outside HALT are ignored.

## Structure
- Shared package `mcu_pkg`: state enum `seq_state_t`, default MEM_TIMEOUT and CNT_W constants.
- Sub-module `wait_timer`: clearable saturating counter with terminal-count output. It is instantiated for the FETCH_READ timeout.

## Test plan
- Reset release with `mem_ready`=1 and `exec_done`=1 tied high: 4-cycle instruction cadence, one `pc_count` pulse per 4 cycles, `instr_count` 0→5 after 20 cycles.
- `mem_ready` delayed 3 cycles: `mem_rd` high exactly 4 cycles, then `ir_load` and `pc_count` in the following cycle. No fault.
- `mem_ready` held 0: `fault`=1 after 16 cycles in FETCH_READ and stays 1. Reset clears it to 0.
- `halt_req` raised mid-EXEC: the current instruction retires, then `halted`=1. A `step` pulse yields exactly one further `exec_start` and a return to HALT. `instr_count` +1.
- `resume` and `step` together in HALT: free-run continues past the next boundary with `halted`=0.
- Reset asserted during FETCH_LATCH: all outputs 0 in the same cycle. Restart at FETCH_ADDR with `instr_count`=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state encoding,
// default sizing constants and the state-to-strobe decode.
package mcu_pkg;

   localparam int unsigned DEF_MEM_TIMEOUT = 15;
   localparam int unsigned DEF_CNT_W       = 16;

   typedef enum logic [2:0] {
      ST_RST,
      ST_FETCH_ADDR,
      ST_FETCH_READ,
      ST_FETCH_LATCH,
      ST_EXEC,
      ST_HALT,
      ST_FAULT
   } seq_state_t;

   typedef struct packed {
      logic pc_out_en;
      logic mar_load;
      logic mem_rd;
      logic ir_load;
      logic pc_count;
      logic exec_start;
      logic bus_grant_exec;
      logic halted;
      logic fault;
   } seq_strobes_t;

   // Strobe pattern for a state; exec_entry marks the first EXEC cycle.
   function automatic seq_strobes_t decode_strobes(input seq_state_t st,
                                                   input logic       exec_entry);
      seq_strobes_t s;
      s = '0;
      case (st)
         ST_FETCH_ADDR: begin
            s.pc_out_en = 1'b1;
            s.mar_load  = 1'b1;
         end
         ST_FETCH_READ:  s.mem_rd = 1'b1;
         ST_FETCH_LATCH: begin
            s.ir_load  = 1'b1;
            s.pc_count = 1'b1;
         end
         ST_EXEC: begin
            s.bus_grant_exec = 1'b1;
            s.exec_start     = exec_entry;
         end
         ST_HALT:  s.halted = 1'b1;
         ST_FAULT: s.fault  = 1'b1;
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake/control bundle between the fetch sequencer and the PC, memory
// interface, execute unit and debug controller.
interface fetch_sequencer_if
   import mcu_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
);
   logic             mem_ready;
   logic             exec_done;
   logic             halt_req;
   logic             resume;
   logic             step;

   logic             pc_out_en;
   logic             mar_load;
   logic             mem_rd;
   logic             ir_load;
   logic             pc_count;
   logic             exec_start;
   logic             bus_grant_exec;
   logic             halted;
   logic             fault;
   logic [CNT_W-1:0] instr_count;

   // Sequencer side.
   modport master (
      input  mem_ready, exec_done, halt_req, resume, step,
      output pc_out_en, mar_load, mem_rd, ir_load, pc_count, exec_start,
             bus_grant_exec, halted, fault, instr_count
   );

   // Memory / execute / debug side.
   modport slave (
      output mem_ready, exec_done, halt_req, resume, step,
      input  pc_out_en, mar_load, mem_rd, ir_load, pc_count, exec_start,
             bus_grant_exec, halted, fault, instr_count
   );
endinterface

// File: rtl/fetch_sequencer_wait_timer.sv
// Clearable saturating cycle counter; o_tc is high while the count sits at TC.
module wait_timer #(
   parameter int unsigned TC = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   localparam int unsigned W    = (TC > 0) ? $clog2(TC + 1) : 1;
   localparam logic [W-1:0] TC_V = W'(TC);

   logic [W-1:0] r_cnt;

   // Count enabled cycles, holding at TC; clear has priority.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != TC_V)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == TC_V);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-cycle controller: fetch address, memory read with timeout,
// IR latch, execute hand-off, halt/single-step debug and timeout fault.
module fetch_sequencer
   import mcu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);
   seq_state_t       r_state;
   seq_state_t       w_next;
   seq_strobes_t     r_strb;
   logic [CNT_W-1:0] r_count;
   logic             r_step;
   logic             w_retire;
   logic             w_step_set;
   logic             w_tmr_clr;
   logic             w_tmr_en;
   logic             w_tmr_tc;

   // The timer is held clear outside FETCH_READ so it starts at 0 on entry.
   assign w_tmr_clr = (r_state != ST_FETCH_READ);
   assign w_tmr_en  = (r_state == ST_FETCH_READ);

   wait_timer #(
      .TC (MEM_TIMEOUT)
   ) u_wait_timer (
      .i_clk (clk),
      .i_rst (reset),
      .i_clr (w_tmr_clr),
      .i_en  (w_tmr_en),
      .o_tc  (w_tmr_tc)
   );

   // Next-state selection, retire and step-request detection.
   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      w_step_set = 1'b0;
      case (r_state)
         ST_RST:         w_next = ST_FETCH_ADDR;
         ST_FETCH_ADDR:  w_next = ST_FETCH_READ;
         ST_FETCH_READ: begin
            if (bus.mem_ready) begin
               w_next = ST_FETCH_LATCH;
            end else if (w_tmr_tc) begin
               w_next = ST_FAULT;
            end
         end
         ST_FETCH_LATCH: w_next = ST_EXEC;
         ST_EXEC: begin
            if (bus.exec_done) begin
               w_retire = 1'b1;
               w_next   = (bus.halt_req || r_step) ? ST_HALT : ST_FETCH_ADDR;
            end
         end
         ST_HALT: begin
            if (bus.resume) begin
               w_next = ST_FETCH_ADDR;
            end else if (bus.step) begin
               w_step_set = 1'b1;
               w_next     = ST_FETCH_ADDR;
            end
         end
         ST_FAULT:       w_next = ST_FAULT;
         default:        w_next = ST_RST;
      endcase
   end

   // State, strobes, retired count and step flag.
   // Strobes are decoded from the next state and registered, so they line up
   // with the state register while never being combinational from inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RST;
         r_strb  <= '0;
         r_count <= '0;
         r_step  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_strb  <= decode_strobes(w_next, (w_next == ST_EXEC) && (r_state != ST_EXEC));
         if (w_retire) begin
            r_count <= r_count + 1'b1;
         end
         if (w_step_set) begin
            r_step <= 1'b1;
         end else if (w_retire) begin
            r_step <= 1'b0;
         end
      end
   end

   assign bus.pc_out_en      = r_strb.pc_out_en;
   assign bus.mar_load       = r_strb.mar_load;
   assign bus.mem_rd         = r_strb.mem_rd;
   assign bus.ir_load        = r_strb.ir_load;
   assign bus.pc_count       = r_strb.pc_count;
   assign bus.exec_start     = r_strb.exec_start;
   assign bus.bus_grant_exec = r_strb.bus_grant_exec;
   assign bus.halted         = r_strb.halted;
   assign bus.fault          = r_strb.fault;
   assign bus.instr_count    = r_count;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver issues instructions with
// chosen memory/execute latencies and pushes the expected per-instruction
// outcome; a monitor measures phases from the outputs and compares on retire
// or fault.
module tb_fetch_sequencer;
   localparam int unsigned MEM_TIMEOUT = 15;
   localparam int unsigned CNT_W       = 16;
   localparam int K_INSTR = 0;
   localparam int K_FAULT = 1;

   typedef struct {
      int kind;
      int rd;
      int ex;
      int cnt;
      bit halt;
   } exp_t;

   logic clk;
   logic reset;
   fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

   fetch_sequencer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_pass  = 0;
   int   n_total = 0;
   int   m_count = 0;
   exp_t exp_q[$];

   task automatic check(input string nm, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
   endtask

   task automatic abort_run(input string nm);
      n_total++;
      $display("FAIL %s: wait bound expired, got no event, expected one", nm);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   function automatic longint outs_all();
      return longint'({bus.pc_out_en, bus.mar_load, bus.mem_rd, bus.ir_load, bus.pc_count,
                       bus.exec_start, bus.bus_grant_exec, bus.halted, bus.fault,
                       bus.instr_count});
   endfunction

   function automatic logic sig_sel(input int which);
      case (which)
         0:       return bus.mem_rd;
         1:       return bus.bus_grant_exec;
         2:       return bus.fault;
         default: return bus.halted;
      endcase
   endfunction

   task automatic wait_sig(input int which, input string nm);
      int n = 0;
      while (!sig_sel(which)) begin
         if (n == 64) abort_run(nm);
         @(negedge clk);
         n++;
      end
   endtask

   // Reference model: one retire per instruction, count wraps at 2^CNT_W.
   task automatic push_instr(input int L, input int E, input bit exp_halt);
      exp_t e;
      m_count = (m_count + 1) % (1 << CNT_W);
      e.kind = K_INSTR;
      e.rd   = L + 1;
      e.ex   = E + 1;
      e.cnt  = m_count;
      e.halt = exp_halt;
      exp_q.push_back(e);
   endtask

   // Drive one instruction: L memory wait cycles, E execute wait cycles.
   task automatic run_instr(input int L, input int E, input bit halt_mid,
                            input bit noise, input bit exp_halt);
      push_instr(L, E, exp_halt);
      wait_sig(0, "wait_mem_rd");
      for (int i = 0; i < L; i++) begin
         if (noise) begin
            bus.resume = 1'($urandom % 2);
            bus.step   = 1'($urandom % 2);
         end
         @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      wait_sig(1, "wait_exec");
      for (int i = 0; i < E; i++) begin
         if (halt_mid) bus.halt_req = 1'b1;
         if (noise) begin
            bus.resume = 1'($urandom % 2);
            bus.step   = 1'($urandom % 2);
         end
         @(negedge clk);
      end
      bus.resume    = 1'b0;
      bus.step      = 1'b0;
      bus.exec_done = 1'b1;
      @(negedge clk);
      bus.exec_done = 1'b0;
   endtask

   task automatic idle_halted(input string nm);
      repeat (4) @(negedge clk);
      check({nm, "_halted"}, bus.halted, 1);
      check({nm, "_count"}, bus.instr_count, m_count);
      check({nm, "_no_fetch"}, {bus.pc_out_en, bus.mem_rd, bus.exec_start}, 0);
   endtask

   // Pulse resume and/or step for one cycle while in HALT.
   task automatic leave_halt(input bit do_resume, input bit do_step);
      check("halted_before_leave", bus.halted, 1);
      bus.resume = do_resume;
      bus.step   = do_step;
      @(negedge clk);
      bus.resume = 1'b0;
      bus.step   = 1'b0;
   endtask

   // Monitor state.
   int mon_last_cnt = 0;
   bit mon_last_fault = 0;
   bit mon_in_instr = 0;
   int mon_len = 0;
   int mon_rd = 0;
   int mon_ex = 0;
   int mon_pcc = 0;
   int mon_es = 0;
   bit mon_es_first = 1;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         mon_last_cnt   = 0;
         mon_last_fault = 0;
         mon_in_instr   = 0;
         mon_len = 0; mon_rd = 0; mon_ex = 0; mon_pcc = 0; mon_es = 0;
      end else begin
         check("pc_bus_exclusive", bus.pc_out_en & bus.bus_grant_exec, 0);
         if (int'(bus.instr_count) != mon_last_cnt) begin
            check("retire_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("retire_kind", K_INSTR, e.kind);
               check("mem_rd_cycles", mon_rd, e.rd);
               check("exec_cycles", mon_ex, e.ex);
               check("instr_cycles", mon_len, e.rd + e.ex + 2);
               check("instr_count", bus.instr_count, e.cnt);
               check("halt_after_retire", bus.halted, e.halt);
               check("pc_count_pulses", mon_pcc, 1);
               check("exec_start_pulses", mon_es, 1);
               check("exec_start_first", mon_es_first, 1);
            end
            mon_last_cnt = int'(bus.instr_count);
         end
         if (bus.fault && !mon_last_fault) begin
            check("fault_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("fault_kind", K_FAULT, e.kind);
               check("fault_mem_rd_cycles", mon_rd, e.rd);
               check("fault_strobes_idle", {bus.pc_out_en, bus.mar_load, bus.mem_rd,
                     bus.ir_load, bus.pc_count, bus.exec_start, bus.bus_grant_exec,
                     bus.halted}, 0);
            end
         end
         mon_last_fault = bus.fault;
         if (bus.pc_out_en) begin
            mon_in_instr = 1;
            mon_len = 0; mon_rd = 0; mon_ex = 0; mon_pcc = 0; mon_es = 0;
            mon_es_first = 1;
         end
         if (mon_in_instr) mon_len++;
         if (bus.mem_rd) mon_rd++;
         if (bus.ir_load && bus.pc_count) mon_pcc++;
         else if (bus.ir_load || bus.pc_count) mon_pcc += 10;
         if (bus.exec_start) begin
            mon_es++;
            if (mon_ex != 0 || !bus.bus_grant_exec) mon_es_first = 0;
         end
         if (bus.bus_grant_exec) mon_ex++;
      end
   end

   initial begin
      exp_t f;
      int   cyc;
      bit   r, s;
      bus.mem_ready = 1'b0;
      bus.exec_done = 1'b0;
      bus.halt_req  = 1'b0;
      bus.resume    = 1'b0;
      bus.step      = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", outs_all(), 0);

      // Free-run with memory and execute both tied ready.
      bus.mem_ready = 1'b1;
      bus.exec_done = 1'b1;
      for (int i = 0; i < 5; i++) push_instr(0, 0, 0);
      reset = 1'b0;
      cyc = 0;
      while (bus.instr_count != 5) begin
         if (cyc == 40) abort_run("tied_cadence");
         @(negedge clk);
         cyc++;
      end
      check("tied_cadence_cycles", cyc, 1 + 5 * 4);
      bus.mem_ready = 1'b0;
      bus.exec_done = 1'b0;

      // Memory latency cases including the timeout-cycle boundary.
      run_instr(3, 0, 0, 0, 0);
      run_instr(MEM_TIMEOUT, 1, 0, 0, 0);
      run_instr(MEM_TIMEOUT - 1, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++)
         run_instr(int'($urandom_range(0, MEM_TIMEOUT)), int'($urandom_range(0, 4)), 0, 1, 0);

      // Halt request mid-execute, then single-step and resume variants.
      run_instr(1, 2, 1, 0, 1);
      idle_halted("halt_mid_exec");
      bus.halt_req = 1'b0;
      leave_halt(0, 1);
      run_instr(1, 1, 0, 0, 1);
      idle_halted("step_no_halt_req");
      bus.halt_req = 1'b1;
      leave_halt(0, 1);
      run_instr(0, 0, 0, 0, 1);
      idle_halted("step_with_halt_req");
      bus.halt_req = 1'b0;
      leave_halt(1, 1);
      run_instr(2, 0, 0, 0, 0);
      run_instr(0, 3, 0, 1, 0);
      check("resume_step_running", bus.halted, 0);

      for (int k = 0; k < 4; k++) begin
         run_instr(int'($urandom_range(0, 5)), int'($urandom_range(1, 3)), 1, 0, 1);
         idle_halted("rand_halt");
         bus.halt_req = 1'($urandom % 2);
         r = 1'($urandom % 2);
         s = ~r | 1'($urandom % 2);
         leave_halt(r, s);
         run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0, 0,
                   bus.halt_req | (s & ~r));
         if (bus.halted) begin
            bus.halt_req = 1'b0;
            leave_halt(1, 0);
         end
         run_instr(0, 0, 0, 1, 0);
      end

      // Reset during FETCH_LATCH.
      wait_sig(0, "wait_mem_rd_rst");
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      check("latch_before_reset", bus.ir_load, 1);
      #1 reset = 1'b1;
      exp_q.delete();
      m_count = 0;
      #1 check("reset_mid_latch_outputs", outs_all(), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("restart_fetch_addr", {bus.pc_out_en, bus.mar_load}, 3);
      check("restart_count", bus.instr_count, 0);
      run_instr(0, 0, 0, 0, 0);
      run_instr(2, 1, 0, 1, 0);

      // Memory timeout fault.
      f.kind = K_FAULT;
      f.rd   = MEM_TIMEOUT + 1;
      f.ex   = 0;
      f.cnt  = m_count;
      f.halt = 0;
      exp_q.push_back(f);
      wait_sig(0, "wait_mem_rd_fault");
      wait_sig(2, "wait_fault");
      for (int i = 0; i < 8; i++) begin
         bus.mem_ready = 1'($urandom % 2);
         bus.exec_done = 1'($urandom % 2);
         bus.resume    = 1'($urandom % 2);
         bus.step      = 1'($urandom % 2);
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      bus.exec_done = 1'b0;
      bus.resume    = 1'b0;
      bus.step      = 1'b0;
      check("fault_sticky", bus.fault, 1);
      check("fault_count_held", bus.instr_count, m_count);
      check("fault_no_strobes", {bus.mem_rd, bus.pc_out_en, bus.halted}, 0);
      reset = 1'b1;
      exp_q.delete();
      m_count = 0;
      repeat (2) @(negedge clk);
      check("fault_cleared_by_reset", outs_all(), 0);
      reset = 1'b0;
      run_instr(1, 0, 0, 0, 0);
      run_instr(0, 2, 0, 1, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
